maj5_input_filter: RTL and testbench
====================================

// Module: maj5_input_filter
// PURPOSE
//   Oversampling glitch filter for asynchronous pad inputs such as I2C SCL/SDA.
//   Sequences the 5-input majority-voter cell generic__maj5: synchronises din and samples it
//   on a programmable prescaler tick into a 5-deep history.
//   Registers the vote as dout and emits rise/fall pulses to the I2C front end.
// PARAMETERS
//   DIV_W        4   prescaler width; sample period = div+1 clk cycles
//   RESET_VAL    1   idle/reset level of sync chain, history and dout (I2C idles high)
//   SYNC_STAGES  2   synchroniser flops on din (>=2)
// PORTS
//   clk         in   1        system clock
//   rst         in   1        synchronous reset, active-high
//   en          in   1        filter enable
//   div         in   DIV_W    prescaler reload value
//   din         in   1        asynchronous raw input
//   dout        out  1        filtered level
//   valid       out  1        dout reflects a full 5-sample vote
//   rise        out  1        1-cycle pulse, dout 0->1
//   fall        out  1        1-cycle pulse, dout 1->0
//   sample_stb  out  1        1-cycle pulse, history shifted this cycle
//   glitch_clr  in   1        [MAJ5_FILTER_GLITCH_CNT_EN only] clear glitch_cnt
//   glitch_cnt  out  8        [MAJ5_FILTER_GLITCH_CNT_EN only] saturating glitch count
// BEHAVIOUR
//   Reset values (edge with rst=1): sync=RESET_VAL, hist={5{RESET_VAL}}, cnt=0, fill=0.
//     Also state=FILL, dout=RESET_VAL, and valid/rise/fall/sample_stb all 0. rst overrides all other inputs.
//   Prescaler: en=0 -> cnt<=div, no tick. en=1: tick=(cnt==0); on tick cnt<=div, else cnt-1.
//     div=0 gives a tick every enabled cycle. A div change takes effect at the next reload only.
//   On a tick edge: hist<={hist[3:0],sync_out}, sample_stb<=1 for one cycle.
//     In FILL, fill also increments.
//   FSM FILL: valid=0, dout held. Advance to RUN on the edge of the 5th tick (fill 4->5).
//   FSM RUN: on the edge after sample_stb, dout<=maj5(hist). Vote latency = 1 clk after history shift.
//     valid<=1 on the first such load.
//   rise/fall: asserted on the edge dout changes, only if valid was already 1.
//     Edges on the first load after FILL are suppressed. rise and fall are never both 1.
//   en 1->0: next edge -> FILL, fill=0, valid=0, pending pulses dropped.
//     dout and hist keep their values. Re-enable refills 5 samples before the next vote.
//   Tick and en-drop in the same cycle: en wins; no shift occurs.
//   End-to-end: a steady din change reaches dout within SYNC_STAGES + 3*(div+1) + 1 clks.
// CONFIGURATION
//   `MAJ5_FILTER_GLITCH_CNT_EN defined:
//     - glitch_clr and glitch_cnt ports exist.
//     - glitch_cnt increments on each RUN vote load where hist is neither 5'b00000 nor 5'b11111.
//     - glitch_cnt saturates at 8'hFF; it is cleared by rst or glitch_clr.
//     - glitch_clr wins over a same-cycle increment.
//   Undefined: both ports absent, no counter logic; all other behaviour identical.
// STRUCTURE
//   Package maj5_filter_pkg: state enum {ST_FILL, ST_RUN}, FILL_DEPTH=5, GLITCH_W=8.
//   Sub-module maj5_sample_prescaler: en/div in, tick out; holds the cnt register.
//   Voting: one generic__maj5 instance fed by hist[4:0] (A=hist[0]..E=hist[4]), so PDK cell mapping applies.
// TESTING
//   1. rst; en=1, div=3, din=1 steady -> sample_stb every 4 clks. valid rises 1 clk after 5th stb.
//      dout=1, with no rise/fall.
//   2. RUN, div=0, din 1->0 steady -> fall pulses once, SYNC_STAGES+3+1 clks after the change. dout=0.
//   3. RUN, div=0, din 0 with a 2-sample 1-glitch -> dout stays 0, no rise.
//      With GLITCH_CNT_EN, glitch_cnt counts the non-unanimous loads.
//   4. en dropped mid-RUN with dout=0 -> valid=0 next clk, dout holds 0.
//      Re-enable with din=1 -> after 5 samples valid=1, dout=1, rise suppressed.
//   5. rst asserted mid-FILL and mid-pulse -> next edge: all outputs at reset values.
//      Also fill=0 and glitch_cnt=0.
//   6. GLITCH_CNT_EN: force 300 glitch votes -> glitch_cnt=8'hFF.
//      glitch_clr concurrent with an increment -> 0.

Source files
------------

// File: rtl/maj5_filter_pkg.sv
// maj5_filter_pkg
//   Shared types and constants for the majority-vote input filter.
//   Contents:
//     state_t        filter sequencing state (fill history / run votes)
//     FILL_DEPTH     number of samples in the vote history
//     GLITCH_W       width of the optional glitch counter
//     is_unanimous   1 when every bit of a history word agrees
package maj5_filter_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int FILL_DEPTH = 5;
    localparam int GLITCH_W   = 8;

    function automatic logic is_unanimous(input logic [FILL_DEPTH-1:0] h);
        return (h == '0) || (h == '1);
    endfunction

endpackage

// File: rtl/generic__maj5.sv
// generic__maj5
//   Behavioural model of the 5-input majority cell; the PDK flow maps this
//   name onto its library cell.
//   Ports:
//     A..E  in   1   vote inputs
//     Y     out  1   1 when at least three inputs are 1
module generic__maj5 (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic E,
    output logic Y
);

    logic [2:0] w_sum;

    assign w_sum = 3'(A) + 3'(B) + 3'(C) + 3'(D) + 3'(E);
    assign Y     = (w_sum >= 3'd3);

endmodule

// File: rtl/maj5_sample_prescaler.sv
// maj5_sample_prescaler
//   Down-counting sample prescaler: one tick every i_div+1 enabled cycles.
//   A new i_div is only picked up at the next reload.
//   Ports:
//     clk     in   1       system clock
//     rst     in   1       synchronous reset, active-high
//     i_en    in   1       count enable; while low the counter preloads i_div
//     i_div   in   DIV_W   reload value
//     o_tick  out  1       sample tick (combinational, only while enabled)
module maj5_sample_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/maj5_input_filter.sv
// maj5_input_filter
//   Oversampling glitch filter for asynchronous pad inputs (I2C SCL/SDA).
//   din is synchronised, sampled on a prescaler tick into a 5-deep history,
//   and the 5-way majority vote is registered as dout with rise/fall pulses.
//
//   state   | meaning
//   ST_FILL | collecting 5 fresh samples; dout held, valid low
//   ST_RUN  | every sample shift is followed one clk later by a vote load
//
//   Ports:
//     clk, rst            system clock, synchronous active-high reset
//     en                  filter enable (drop returns to ST_FILL)
//     div                 prescaler reload; sample period = div+1 clks
//     din                 asynchronous raw input
//     dout, valid         filtered level and "dout is a full vote"
//     rise, fall          1-clk edge pulses on dout (not on the first vote)
//     sample_stb          1-clk pulse, history shifted this cycle
//     glitch_clr, glitch_cnt
//                         only with MAJ5_FILTER_GLITCH_CNT_EN defined:
//                         saturating count of non-unanimous vote loads
module maj5_input_filter
    import maj5_filter_pkg::*;
#(
    parameter int   DIV_W       = 4,
    parameter logic RESET_VAL   = 1'b1,
    parameter int   SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             din,
    output logic             dout,
    output logic             valid,
    output logic             rise,
    output logic             fall,
    output logic             sample_stb
`ifdef MAJ5_FILTER_GLITCH_CNT_EN
    ,
    input  logic                glitch_clr,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILL_DEPTH-1:0]  r_hist;
    logic [2:0]             r_fill;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_dout;
    logic                   r_valid;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_sample_stb;
    logic                   w_tick;
    logic                   w_vote;
    logic                   w_load;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    maj5_sample_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (en),
        .i_div  (div),
        .o_tick (w_tick)
    );

    generic__maj5 u_maj5 (
        .A (r_hist[0]),
        .B (r_hist[1]),
        .C (r_hist[2]),
        .D (r_hist[3]),
        .E (r_hist[4]),
        .Y (w_vote)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_tick && (r_fill == 3'(FILL_DEPTH - 1))) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ST_FILL;
                end else begin
                    // vote the history one clk after it was shifted
                    w_load = r_sample_stb;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= {SYNC_STAGES{RESET_VAL}};
            r_hist       <= {FILL_DEPTH{RESET_VAL}};
            r_fill       <= '0;
            r_dout       <= RESET_VAL;
            r_valid      <= 1'b0;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_sample_stb <= 1'b0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], din};
            r_sample_stb <= w_tick;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            if (!en) begin
                // hist and dout deliberately keep their last values
                r_fill  <= '0;
                r_valid <= 1'b0;
            end else begin
                if (w_tick) begin
                    r_hist <= {r_hist[FILL_DEPTH-2:0], w_sync_out};
                    if (r_state == ST_FILL) begin
                        r_fill <= r_fill + 3'd1;
                    end
                end
                if (w_load) begin
                    r_dout  <= w_vote;
                    r_valid <= 1'b1;
                    // first load after a fill is not an edge
                    r_rise  <= r_valid && !r_dout && w_vote;
                    r_fall  <= r_valid && r_dout && !w_vote;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign valid      = r_valid;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign sample_stb = r_sample_stb;

`ifdef MAJ5_FILTER_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] r_glitch_cnt;

    always_ff @(posedge clk) begin
        if (rst || glitch_clr) begin
            r_glitch_cnt <= '0;
        end else if (w_load && !is_unanimous(r_hist) && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + 1'b1;
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_maj5_input_filter.sv
// tb_maj5_input_filter
//   Directed scenarios plus a randomised phase for maj5_input_filter.
//   A reference model predicts every cycle's outputs; predictions are queued
//   when inputs are driven and popped when the DUT outputs are sampled.
module tb_maj5_input_filter;

    localparam int   DIV_W       = 4;
    localparam logic RESET_VAL   = 1'b1;
    localparam int   SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic             din;
    logic             glitch_clr;
    logic             dout, valid, rise, fall, sample_stb;
`ifdef MAJ5_FILTER_GLITCH_CNT_EN
    logic [7:0]       glitch_cnt;
`endif

    always #5 clk = ~clk;

    maj5_input_filter #(
        .DIV_W       (DIV_W),
        .RESET_VAL   (RESET_VAL),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div        (div),
        .din        (din),
        .dout       (dout),
        .valid      (valid),
        .rise       (rise),
        .fall       (fall),
        .sample_stb (sample_stb)
`ifdef MAJ5_FILTER_GLITCH_CNT_EN
        ,
        .glitch_clr (glitch_clr),
        .glitch_cnt (glitch_cnt)
`endif
    );

    typedef struct packed {
        logic       dout;
        logic       valid;
        logic       rise;
        logic       fall;
        logic       stb;
        logic [7:0] gc;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_rise   = 0;
    int n_fall   = 0;

    // reference model state
    logic [SYNC_STAGES-1:0] m_sync;
    logic [4:0]             m_hist;
    int                     m_cnt;
    int                     m_fill;
    bit                     m_run;
    logic                   m_dout, m_valid, m_rise, m_fall, m_stb;
    int                     m_gc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Advances the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic so, tick, load, vote;
        int   ones;
        if (rst) begin
            m_sync  = {SYNC_STAGES{RESET_VAL}};
            m_hist  = {5{RESET_VAL}};
            m_cnt   = 0;
            m_fill  = 0;
            m_run   = 0;
            m_dout  = RESET_VAL;
            m_valid = 0;
            m_rise  = 0;
            m_fall  = 0;
            m_stb   = 0;
            m_gc    = 0;
        end else begin
            so   = m_sync[SYNC_STAGES-1];
            tick = en && (m_cnt == 0);
            load = en && m_run && m_stb;
            ones = $countones(m_hist);
            vote = (ones >= 3);
            m_rise = 0;
            m_fall = 0;
            if (glitch_clr) m_gc = 0;
            else if (load && ones != 0 && ones != 5 && m_gc != 255) m_gc++;
            if (load) begin
                if (m_valid && vote != m_dout) begin
                    m_rise = vote;
                    m_fall = !vote;
                end
                m_dout  = vote;
                m_valid = 1;
            end
            if (!en) begin
                m_fill  = 0;
                m_run   = 0;
                m_valid = 0;
                m_cnt   = int'(div);
            end else if (tick) begin
                m_hist = {m_hist[3:0], so};
                if (!m_run) begin
                    m_fill++;
                    if (m_fill == 5) m_run = 1;
                end
                m_cnt = int'(div);
            end else begin
                m_cnt--;
            end
            m_stb  = tick;
            m_sync = {m_sync[SYNC_STAGES-2:0], din};
        end
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        sb_q.push_back({m_dout, m_valid, m_rise, m_fall, m_stb, 8'(m_gc)});
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        chk("dout", 32'(dout), 32'(e.dout));
        chk("valid", 32'(valid), 32'(e.valid));
        chk("rise", 32'(rise), 32'(e.rise));
        chk("fall", 32'(fall), 32'(e.fall));
        chk("sample_stb", 32'(sample_stb), 32'(e.stb));
        chk("rise_fall_excl", 32'(rise & fall), 32'd0);
`ifdef MAJ5_FILTER_GLITCH_CNT_EN
        chk("glitch_cnt", 32'(glitch_cnt), 32'(e.gc));
`endif
        if (rise === 1'b1) n_rise++;
        if (fall === 1'b1) n_fall++;
    endtask

    initial begin
        int stbs[$];
        int vcyc, c0, r0, f0, g0;
        bit got;

        rst = 1; en = 0; div = 4'd3; din = 1; glitch_clr = 0;
        step();
        step();
        chk("rst_dout", 32'(dout), 32'(RESET_VAL));
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_stb", 32'(sample_stb), 32'd0);

        // 1: div=3, din steady high
        rst = 0; en = 1;
        vcyc = -1;
        r0 = n_rise; f0 = n_fall;
        for (int i = 0; i < 24; i++) begin
            step();
            if (sample_stb) stbs.push_back(cyc);
            if (valid && vcyc < 0) vcyc = cyc;
        end
        if (stbs.size() >= 5) begin
            chk("t1_stb_period", 32'(stbs[1] - stbs[0]), 32'd4);
            chk("t1_valid_lat", 32'(vcyc - stbs[4]), 32'd1);
        end else begin
            chk("t1_stb_count", 32'(stbs.size()), 32'd5);
        end
        chk("t1_dout", 32'(dout), 32'd1);
        chk("t1_no_edges", 32'((n_rise - r0) + (n_fall - f0)), 32'd0);

        // 2: div=0, din 1->0
        div = 4'd0;
        for (int i = 0; i < 6; i++) step();
        din = 0;
        c0 = cyc; f0 = n_fall; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (fall) got = 1;
        end
        chk("t2_fall_lat", got ? 32'(cyc - c0) : 32'hFFFF_FFFF, 32'(SYNC_STAGES + 4));
        for (int i = 0; i < 3; i++) step();
        chk("t2_dout", 32'(dout), 32'd0);
        chk("t2_fall_once", 32'(n_fall - f0), 32'd1);

        // 3: two-sample high glitch on a low line
        r0 = n_rise;
`ifdef MAJ5_FILTER_GLITCH_CNT_EN
        g0 = int'(glitch_cnt);
`else
        g0 = 0;
`endif
        din = 1; step(); step();
        din = 0;
        for (int i = 0; i < 12; i++) step();
        chk("t3_dout", 32'(dout), 32'd0);
        chk("t3_no_rise", 32'(n_rise - r0), 32'd0);
`ifdef MAJ5_FILTER_GLITCH_CNT_EN
        chk("t3_glitch_delta", 32'(int'(glitch_cnt) - g0), 32'd6);
`endif

        // 4: drop enable mid-RUN, re-enable with din high
        en = 0;
        step();
        chk("t4_valid_drop", 32'(valid), 32'd0);
        chk("t4_dout_hold", 32'(dout), 32'd0);
        din = 1;
        for (int i = 0; i < 3; i++) step();
        en = 1;
        r0 = n_rise;
        for (int i = 0; i < 10; i++) step();
        chk("t4_valid", 32'(valid), 32'd1);
        chk("t4_dout", 32'(dout), 32'd1);
        chk("t4_rise_suppr", 32'(n_rise - r0), 32'd0);

        // 5a: reset mid-FILL
        en = 0; step();
        en = 1; step(); step();
        rst = 1; step();
        chk("t5_dout", 32'(dout), 32'(RESET_VAL));
        chk("t5_valid", 32'(valid), 32'd0);
        chk("t5_stb", 32'(sample_stb), 32'd0);
        rst = 0;
        vcyc = -1; c0 = cyc;
        for (int i = 0; i < 9; i++) begin
            step();
            if (valid && vcyc < 0) vcyc = cyc;
        end
        chk("t5_refill_len", 32'(vcyc - c0), 32'd6);

        // 5b: reset on the cycle a fall pulse is visible
        din = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (fall) got = 1;
        end
        chk("t5_fall_seen", 32'(got), 32'd1);
        rst = 1; step();
        chk("t5p_fall", 32'(fall), 32'd0);
        chk("t5p_dout", 32'(dout), 32'(RESET_VAL));
        chk("t5p_valid", 32'(valid), 32'd0);
`ifdef MAJ5_FILTER_GLITCH_CNT_EN
        chk("t5p_glitch", 32'(glitch_cnt), 32'd0);
`endif
        rst = 0;

        // randomised phase
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 5) == 0) din = ~din;
            if ($urandom_range(0, 30) == 0) div = 4'($urandom_range(0, 3));
            glitch_clr = ($urandom_range(0, 60) == 0);
            rst = ($urandom_range(0, 150) == 0);
            step();
        end
        rst = 0; glitch_clr = 0; en = 1; div = 4'd0;

`ifdef MAJ5_FILTER_GLITCH_CNT_EN
        // 6: saturation and clear priority
        for (int i = 0; i < 320; i++) begin
            din = ~din;
            step();
        end
        chk("t6_saturate", 32'(glitch_cnt), 32'hFF);
        din = ~din;
        glitch_clr = 1;
        step();
        chk("t6_clr_wins", 32'(glitch_cnt), 32'd0);
        glitch_clr = 0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
